fetch_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of decode.
- Owns the fetch PC and drives a ready/valid instruction-memory port.
- Drives the IF/ID pipeline register whose instr_d[6:0] feeds the decode control logic.
- Applies hazard-unit stall/flush and execute-stage branch/jump redirects; discards in-flight responses made stale by a redirect.

---
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction fetch stage with a single-outstanding imem port and IF/ID register.
module fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_f,
  input  logic            flush_d,
  input  logic            pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc_f, pc_n, pc_f_plus4;
  logic [31:0]     hold_instr, hold_n;
  logic            load_en;
  logic [31:0]     load_instr;

  assign pc_f_plus4 = pc_f + PC_STEP;
  assign imem_req   = rst_n && (state == S_REQ);
  assign imem_addr  = pc_f;

  always_comb begin
    state_n    = state;
    pc_n       = pc_f;
    hold_n     = hold_instr;
    load_en    = 1'b0;
    load_instr = hold_instr;
    case (state)
      S_REQ: begin
        if (imem_ready) state_n = pc_src_e ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (pc_src_e) begin
          state_n = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          if (stall_f) begin
            hold_n  = imem_rdata;
            state_n = S_HOLD;
          end else begin
            load_en    = 1'b1;
            load_instr = imem_rdata;
            pc_n       = pc_f_plus4;
            state_n    = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (pc_src_e) begin
          state_n = S_REQ;
        end else if (!stall_f) begin
          load_en = 1'b1;
          pc_n    = pc_f_plus4;
          state_n = S_REQ;
        end
      end
      S_DROP: begin
        // The stale response retires the outstanding request even if another redirect lands with it.
        if (imem_rvalid) state_n = S_REQ;
      end
      default: state_n = S_REQ;
    endcase
    if (pc_src_e) pc_n = pc_target_e;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_REQ;
      pc_f       <= RESET_PC;
      hold_instr <= NOP_INSTR;
    end else begin
      state      <= state_n;
      pc_f       <= pc_n;
      hold_instr <= hold_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (flush_d) begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end else if (!stall_f) begin
      if (load_en) begin
        instr_d    <= load_instr;
        pc_d       <= pc_f;
        pc_plus4_d <= pc_f_plus4;
        valid_d    <= 1'b1;
      end else begin
        instr_d <= NOP_INSTR;
        valid_d <= 1'b0;
      end
    end
  end

  // A response may only arrive while a request is outstanding.
  assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (state == S_WAIT || state == S_DROP));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a program-order fetch model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_f = 1'b0, flush_d = 1'b0, pc_src_e = 1'b0;
  logic [31:0] pc_target_e = '0;
  logic        imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, valid_d, imem_req2, valid_d2;
  logic [31:0] imem_addr, instr_d, pc_d, pc_plus4_d;
  logic [31:0] imem_addr2, instr_d2, pc_d2, pc_plus4_d2;

  int checks = 0;
  int errors = 0;

  bit          mem_busy;
  int unsigned mem_cnt, lat_lo, lat_hi;
  logic [31:0] mem_addr;
  bit          rdy_rand;

  bit          fire, rv, e_stall, e_redir;
  logic [31:0] fire_addr, e_tgt, p_instr, p_pc, p_pc4;
  logic        p_valid;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_d(instr_d2), .pc_d(pc_d2), .pc_plus4_d(pc_plus4_d2), .valid_d(valid_d2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0003;
  endfunction

  // One clock of the memory model: drive response/ready, record edge inputs, advance latency.
  task automatic step();
    imem_rvalid = mem_busy && (mem_cnt == 0);
    imem_rdata  = imem_rvalid ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    imem_ready  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    fire = imem_req && imem_ready;
    fire_addr = imem_addr;
    rv = imem_rvalid;
    e_stall = stall_f;
    e_redir = pc_src_e;
    e_tgt = pc_target_e;
    p_instr = instr_d;
    p_pc = pc_d;
    p_pc4 = pc_plus4_d;
    p_valid = valid_d;
    @(posedge clk);
    @(negedge clk);
    if (rv) mem_busy = 1'b0;
    else if (mem_busy && mem_cnt > 0) mem_cnt--;
    if (fire) begin
      mem_busy = 1'b1;
      mem_addr = fire_addr;
      mem_cnt  = $urandom_range(lat_hi, lat_lo);
    end
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    stall_f = 1'b0; flush_d = 1'b0; pc_src_e = 1'b0; pc_target_e = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0;
    lat_lo = 0; lat_hi = 0; rdy_rand = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    hold_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    hold_reset();
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", imem_req); end
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid_d); end
    checks++; if (instr_d !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", instr_d, NOP); end
    checks++; if (pc_d !== 32'h0 || pc_plus4_d !== 32'h0) begin errors++; $display("FAIL reset_pc got %h/%h want 0/0", pc_d, pc_plus4_d); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", imem_addr); end
    checks++; if (imem_addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_addr_wrap got %h want fffffffc", imem_addr2); end
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL release_req got %0b want 1", imem_req); end
  endtask

  task automatic test_zero_wait();
    do_reset();
    step();
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL zw_valid0 got %0b want 0", valid_d); end
    step();
    checks++; if (valid_d !== 1'b1 || instr_d !== 32'h0050_0093) begin errors++; $display("FAIL zw_instr0 got %0b/%h want 1/00500093", valid_d, instr_d); end
    checks++; if (pc_d !== 32'h0 || pc_plus4_d !== 32'h4) begin errors++; $display("FAIL zw_pc0 got %h/%h want 0/4", pc_d, pc_plus4_d); end
    checks++; if (pc_d2 !== 32'hFFFF_FFFC || pc_plus4_d2 !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h/%h want fffffffc/0", pc_d2, pc_plus4_d2); end
    checks++; if (imem_addr2 !== 32'h0 || imem_req2 !== 1'b1) begin errors++; $display("FAIL wrap_next_addr got %h req %0b want 0 req 1", imem_addr2, imem_req2); end
    checks++; if (instr_d2 !== instr_d || valid_d2 !== 1'b1) begin errors++; $display("FAIL wrap_instr got %h/%0b want %h/1", instr_d2, valid_d2, instr_d); end
    step();
    checks++; if (valid_d !== 1'b0 || instr_d !== NOP) begin errors++; $display("FAIL zw_bubble got %0b/%h want 0/%h", valid_d, instr_d, NOP); end
    step();
    checks++; if (valid_d !== 1'b1 || instr_d !== 32'h0010_0113) begin errors++; $display("FAIL zw_instr1 got %0b/%h want 1/00100113", valid_d, instr_d); end
    checks++; if (pc_d !== 32'h4 || pc_plus4_d !== 32'h8) begin errors++; $display("FAIL zw_pc1 got %h/%h want 4/8", pc_d, pc_plus4_d); end
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL zw_addr got %h want 8", imem_addr); end
  endtask

  task automatic test_stall_hold();
    do_reset();
    step();
    step();
    stall_f = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_req !== 1'b0 && i > 0) begin errors++; $display("FAIL stall_req cycle %0d got %0b want 0", i, imem_req); end
      checks++; if (valid_d !== 1'b1 || instr_d !== 32'h0050_0093 || pc_d !== 32'h0) begin errors++; $display("FAIL stall_ifid cycle %0d got %0b/%h/%h want 1/00500093/0", i, valid_d, instr_d, pc_d); end
    end
    stall_f = 1'b0;
    step();
    checks++; if (valid_d !== 1'b1 || instr_d !== 32'h0010_0113 || pc_d !== 32'h4) begin errors++; $display("FAIL hold_release got %0b/%h/%h want 1/00100113/4", valid_d, instr_d, pc_d); end
    checks++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin errors++; $display("FAIL hold_next got %h req %0b want 8 req 1", imem_addr, imem_req); end
    step();
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL hold_once got %0b want 0", valid_d); end
  endtask

  task automatic test_redirect_wait();
    bit seen;
    do_reset();
    lat_lo = 2; lat_hi = 2;
    step();
    lat_lo = 0; lat_hi = 0;
    pc_src_e = 1'b1; pc_target_e = 32'h100;
    step();
    pc_src_e = 1'b0; pc_target_e = '0;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h100) begin errors++; $display("FAIL drop_state got req %0b addr %h want 0/100", imem_req, imem_addr); end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL stale_leak got %0b instr %h want 0", valid_d, instr_d); end
      seen = imem_req;
    end
    checks++; if (!seen) begin errors++; $display("FAIL drop_timeout got req 0 want 1"); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL redirect_addr got %h want 100", imem_addr); end
    step();
    step();
    checks++; if (valid_d !== 1'b1 || instr_d !== mem_word(32'h100) || pc_d !== 32'h100) begin errors++; $display("FAIL redirect_fetch got %0b/%h/%h want 1/%h/100", valid_d, instr_d, pc_d, mem_word(32'h100)); end
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    step();
    pc_src_e = 1'b1; pc_target_e = 32'h40;
    step();
    pc_src_e = 1'b0; pc_target_e = '0;
    checks++; if (valid_d !== 1'b0 || instr_d !== NOP) begin errors++; $display("FAIL rv_redir_discard got %0b/%h want 0/%h", valid_d, instr_d, NOP); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL rv_redir_req got %0b/%h want 1/40", imem_req, imem_addr); end
  endtask

  task automatic test_flush_stall();
    do_reset();
    step();
    step();
    checks++; if (valid_d !== 1'b1) begin errors++; $display("FAIL flush_pre got %0b want 1", valid_d); end
    flush_d = 1'b1; stall_f = 1'b1;
    step();
    flush_d = 1'b0; stall_f = 1'b0;
    checks++; if (valid_d !== 1'b0 || instr_d !== NOP) begin errors++; $display("FAIL flush_over_stall got %0b/%h want 0/%h", valid_d, instr_d, NOP); end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (5) step();
    checks++; if (pc_d !== 32'h4 || imem_addr !== 32'h8) begin errors++; $display("FAIL areset_pre got %h/%h want 4/8", pc_d, imem_addr); end
    rst_n = 1'b0;
    #2;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || imem_addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL areset_port got %0b/%h/%h want 0/0/fffffffc", imem_req, imem_addr, imem_addr2); end
    checks++; if (valid_d !== 1'b0 || instr_d !== NOP || pc_d !== 32'h0 || pc_plus4_d !== 32'h0) begin errors++; $display("FAIL areset_ifid got %0b/%h/%h/%h want 0/%h/0/0", valid_d, instr_d, pc_d, pc_plus4_d, NOP); end
    do_reset();
  endtask

  // Model: valid instructions leave IF/ID in program order from the latest redirect target.
  task automatic test_random();
    logic [31:0] exp_pc;
    int delivered;
    do_reset();
    lat_lo = 0; lat_hi = 3; rdy_rand = 1'b1;
    exp_pc = 32'h0;
    delivered = 0;
    for (int c = 0; c < 800; c++) begin
      stall_f  = ($urandom_range(0, 3) == 0);
      pc_src_e = ($urandom_range(0, 29) == 0);
      pc_target_e = !pc_src_e ? 32'h0 : ($urandom_range(0, 1) == 1) ? ($urandom & 32'h0000_FFFC) : 32'hFFFF_FFF8;
      step();
      if (e_stall) begin
        checks++; if (valid_d !== p_valid || instr_d !== p_instr || pc_d !== p_pc || pc_plus4_d !== p_pc4) begin errors++; $display("FAIL rnd_stall_hold cycle %0d got %0b/%h/%h want %0b/%h/%h", c, valid_d, instr_d, pc_d, p_valid, p_instr, p_pc); end
      end else if (valid_d) begin
        checks++;
        if (e_redir) begin
          errors++; $display("FAIL rnd_load_on_redirect cycle %0d got pc %h want no load", c, pc_d);
        end else if (pc_d !== exp_pc || instr_d !== mem_word(exp_pc) || pc_plus4_d !== exp_pc + 32'h4) begin
          errors++; $display("FAIL rnd_order cycle %0d got %h/%h/%h want %h/%h/%h", c, pc_d, instr_d, pc_plus4_d, exp_pc, mem_word(exp_pc), exp_pc + 32'h4);
        end
        exp_pc = exp_pc + 32'h4;
        delivered++;
      end else begin
        checks++; if (instr_d !== NOP) begin errors++; $display("FAIL rnd_bubble cycle %0d got %h want %h", c, instr_d, NOP); end
      end
      if (e_redir) exp_pc = e_tgt;
    end
    stall_f = 1'b0; pc_src_e = 1'b0; pc_target_e = '0;
    checks++; if (delivered < 20) begin errors++; $display("FAIL rnd_progress got %0d want >= 20", delivered); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall_hold();
    test_redirect_wait();
    test_redirect_rvalid();
    test_flush_stall();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
